fractal_sync_req_scheduler: RTL

FRACTAL_SYNC_REQ_SCHEDULER -- requirements
Module: fractal_sync_req_scheduler

---
 rtl/fractal_sync_req_scheduler.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/fractal_sync_req_scheduler.sv
// Fractal sync request scheduler: queues {aggr,id} requests and issues them one at a time
// to the tree/neighbor sync ports. Wake timeout enabled by FSYNC_REQ_SCHED_TIMEOUT_EN.
module fractal_sync_req_scheduler #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned AGGR_W     = 8,
  parameter int unsigned ID_W       = 8,
  parameter int unsigned NBR_AGGR_W = 2,
  parameter int unsigned NBR_ID_W   = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned TIMEOUT_W  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clear_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [DATA_W-1:0]            req_aggr_i,
  input  logic [DATA_W-1:0]            req_id_i,
  output logic [3:0]                   sync_o,
  output logic [4*AGGR_W-1:0]          aggr_o,
  output logic [4*ID_W-1:0]            id_req_o,
  input  logic [3:0]                   wake_i,
  input  logic [3:0]                   error_i,
  output logic                         done_o,
  output logic                         timeout_o,
  output logic [$clog2(DEPTH+1)-1:0]   pending_o,
  output logic                         error_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StSync, StWait, StDone} state_e;

  state_e state_q, state_d;
  logic [1:0] port_q, port_d;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;
  logic                full, empty, push, pop;

  logic [DATA_W-1:0]   head_aggr, head_id;
  logic [1:0]          sel_port;
  logic                wake_hit;
  logic                expired;
  logic                sticky;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign req_ready_o = !full;
  assign pending_o   = count_q;
  assign push        = req_valid_i && !full && !clear_i;
  assign pop         = (state_q == StDone) && !clear_i && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage carries no reset; only entries below count_q are ever observed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {req_aggr_i, req_id_i};
  end

  assign {head_aggr, head_id} = mem_q[rd_ptr_q];

  // aggr == 1 selects among all four ports; anything else only the two tree ports.
  assign sel_port = (head_aggr == DATA_W'(1)) ? head_id[1:0] : {1'b0, head_id[0]};
  assign wake_hit = wake_i[port_q];

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      port_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    if (clear_i) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            state_d = StSync;
            port_d  = sel_port;
          end
        end
        StSync: state_d = wake_hit ? StDone : StWait;
        StWait: begin
          if (wake_hit || expired) state_d = StDone;
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Port outputs: only the issued port is driven, and only in the SYNC cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    sync_o   = '0;
    aggr_o   = '0;
    id_req_o = '0;
    if ((state_q == StSync) && !clear_i) begin
      for (int p = 0; p < 4; p++) begin
        if (port_q == 2'(p)) begin
          sync_o[p] = 1'b1;
          if (p < 2) begin
            aggr_o[p*AGGR_W +: AGGR_W] = head_aggr[AGGR_W-1:0];
            id_req_o[p*ID_W +: ID_W]   = head_id[ID_W-1:0];
          end else begin
            aggr_o[p*AGGR_W +: AGGR_W] = AGGR_W'(head_aggr[NBR_AGGR_W-1:0]);
            id_req_o[p*ID_W +: ID_W]   = ID_W'(head_id[NBR_ID_W-1:0]);
          end
        end
      end
    end
  end

  assign done_o  = (state_q == StDone) && !clear_i;
  assign error_o = (|error_i) || sticky;

  // ---------------------------------------------------------------------------
  // Optional wake timeout
  // ---------------------------------------------------------------------------
`ifdef FSYNC_REQ_SCHED_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;
  logic                 sticky_q, sticky_d;

  assign expired = &cnt_q;

  always_comb begin
    cnt_d    = '0;
    tmo_d    = 1'b0;
    sticky_d = sticky_q;
    if (clear_i) begin
      sticky_d = 1'b0;
    end else if (state_q == StWait) begin
      cnt_d = cnt_q + 1'b1;
      // A wake arriving on the last count wins over the timeout.
      if (!wake_hit && expired) begin
        tmo_d    = 1'b1;
        sticky_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      sticky_q <= sticky_d;
    end
  end

  assign timeout_o = (state_q == StDone) && tmo_q && !clear_i;
  assign sticky    = sticky_q;
`else
  logic [TIMEOUT_W-1:0] unused_timeout_cnt;

  assign unused_timeout_cnt = '0;
  assign expired            = 1'b0;
  assign timeout_o          = 1'b0;
  assign sticky             = 1'b0;
`endif

  // Upper operand bits beyond the port field widths are intentionally dropped.
  logic unused_head_bits;
  assign unused_head_bits = ^{head_aggr, head_id};

endmodule
